// File: rtl/amul_err_monitor.sv
// Error-metric monitor for an approximate 8x8 multiplier: accumulates error distance statistics over a run.
// Optional macro AMUL_ERR_SIGNED_EN builds the signed-error (bias) accumulator behind sum_sed.
module amul_err_monitor #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           x,
    input  logic [7:0]           y,
    input  logic [15:0]          z_approx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [16+CNT_W-1:0]  sum_ed,
    output logic [15:0]          max_ed,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [17+CNT_W-1:0]  sum_sed
);

    localparam int unsigned SUM_W  = 16 + CNT_W;
    localparam int unsigned SSUM_W = 17 + CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic             drain_cnt;
    logic             start_ok;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    logic             s1_valid;
    logic [15:0]      s1_exact;
    logic [15:0]      s1_z;
    logic [15:0]      ed;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign accept   = (state == RUN) && in_valid && in_ready;
    assign cnt_inc  = sample_cnt + CNT_W'(1);

    // Run control: sample acceptance window, two-cycle pipeline flush, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_lat      <= '0;
            drain_cnt  <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        n_lat      <= num_samples;
                        sample_cnt <= '0;
                        in_ready   <= (num_samples != '0);
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    if (n_lat == '0) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                        in_ready  <= 1'b0;
                    end else if (accept) begin
                        sample_cnt <= cnt_inc;
                        if (cnt_inc == n_lat) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: exact reference product alongside the approximate one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_exact <= '0;
            s1_z     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_exact <= 16'(x) * 16'(y);
                s1_z     <= z_approx;
            end
        end
    end

    always_comb begin
        ed = '0;
        if (s1_z >= s1_exact) begin
            ed = s1_z - s1_exact;
        end else begin
            ed = s1_exact - s1_z;
        end
    end

    // Stage 2: unsigned error statistics.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (s1_valid) begin
            sum_ed <= sum_ed + SUM_W'(ed);
            if (ed > max_ed) begin
                max_ed <= ed;
            end
            if (ed != '0) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

`ifdef AMUL_ERR_SIGNED_EN
    logic signed [16:0]  sed;
    logic [SSUM_W-1:0]   sed_acc;

    assign sed = $signed({1'b0, s1_z}) - $signed({1'b0, s1_exact});

    // Signed bias accumulator; sed is sign-extended into the wide sum.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            sed_acc <= '0;
        end else if (s1_valid) begin
            sed_acc <= sed_acc + SSUM_W'(sed);
        end
    end

    assign sum_sed = sed_acc;
`else
    assign sum_sed = '0;
`endif

endmodule

// File: tb/tb_amul_err_monitor.sv
// Scoreboard bench for amul_err_monitor: random runs checked against an arithmetic reference model.
module tb_amul_err_monitor;

    localparam int unsigned CNT_W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [CNT_W-1:0]    num_samples;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          x;
    logic [7:0]          y;
    logic [15:0]         z_approx;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    sample_cnt;
    logic [16+CNT_W-1:0] sum_ed;
    logic [15:0]         max_ed;
    logic [CNT_W-1:0]    err_cnt;
    logic [17+CNT_W-1:0] sum_sed;

    amul_err_monitor #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z_approx(z_approx),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .sum_ed(sum_ed),
        .max_ed(max_ed), .err_cnt(err_cnt), .sum_sed(sum_sed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
    } smp_t;

    typedef struct {
        longint cnt;
        longint sum_ed;
        longint max_ed;
        longint err;
        longint sed;
    } exp_t;

    smp_t stim_q[$];
    bit   pat_q[$];
    exp_t exp_q[$];
    exp_t held;
    bit   held_ok = 1'b0;
    bit   done_q  = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: error metrics straight from the definition, over the first n queued samples.
    function automatic exp_t model(input int n);
        exp_t e;
        e.cnt = n; e.sum_ed = 0; e.max_ed = 0; e.err = 0; e.sed = 0;
        for (int i = 0; i < n; i++) begin
            longint exact = longint'(stim_q[i].x) * longint'(stim_q[i].y);
            longint d     = longint'(stim_q[i].z) - exact;
            longint ad    = (d < 0) ? -d : d;
            e.sum_ed += ad;
            if (ad > e.max_ed) e.max_ed = ad;
            if (ad != 0) e.err++;
            e.sed += d;
        end
`ifndef AMUL_ERR_SIGNED_EN
        e.sed = 0;
`endif
        return e;
    endfunction

    // Monitor: pops an expectation when done rises and checks results for as long as done holds.
    always @(negedge clk) begin
        if (rst) begin
            held_ok = 1'b0;
        end else begin
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
                end else begin
                    held    = exp_q.pop_front();
                    held_ok = 1'b1;
                end
            end
            if (done && held_ok) begin
                check("sample_cnt", longint'(sample_cnt), held.cnt);
                check("sum_ed",     longint'(sum_ed),     held.sum_ed);
                check("max_ed",     longint'(max_ed),     held.max_ed);
                check("err_cnt",    longint'(err_cnt),    held.err);
                check("sum_sed",    longint'($signed(sum_sed)), held.sed);
            end
        end
        done_q = done;
    end

    task automatic add(input int ax, input int ay, input int az);
        smp_t s;
        s.x = 8'(ax); s.y = 8'(ay); s.z = 16'(az);
        stim_q.push_back(s);
    endtask

    task automatic gen_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) begin
            int ax = int'($urandom_range(255));
            int ay = int'($urandom_range(255));
            int ex = ax * ay;
            int az;
            case ($urandom_range(3))
                0:       az = ex;
                1:       az = ex + int'($urandom_range(600)) - 300;
                2:       az = int'($urandom_range(65535));
                default: az = ex + int'($urandom_range(40000)) - 20000;
            endcase
            if (az < 0) az = 0;
            if (az > 65535) az = 65535;
            add(ax, ay, az);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"},   longint'(in_ready),   0);
        check({tag, "_busy"},       longint'(busy),       0);
        check({tag, "_done"},       longint'(done),       0);
        check({tag, "_sample_cnt"}, longint'(sample_cnt), 0);
        check({tag, "_sum_ed"},     longint'(sum_ed),     0);
        check({tag, "_max_ed"},     longint'(max_ed),     0);
        check({tag, "_err_cnt"},    longint'(err_cnt),    0);
        check({tag, "_sum_sed"},    longint'(sum_sed),    0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=0 required=1 at %0t", $time);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Issues a run of n samples from stim_q; gaps from pat_q if present, else random at gap_pct.
    task automatic run_samples(input int n, input int gap_pct, input bit poke);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit acc;
        exp_q.push_back(model(n));
        @(posedge clk); #1;
        start = 1'b1;
        num_samples = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < n && cyc < 2000) begin
            if (pat_q.size() > 0) v = pat_q.pop_front();
            else v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            x        = stim_q[idx].x;
            y        = stim_q[idx].y;
            z_approx = stim_q[idx].z;
            if (poke && cyc == 2) begin
                start       = 1'b1;
                num_samples = CNT_W'(n + 5);
            end else begin
                start = 1'b0;
            end
            acc = v && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < n) begin
            total++;
            bad++;
            $display("FAIL feed_timeout actual=%0d required=%0d", idx, n);
        end
        check("in_ready_drop", longint'(in_ready), 0);
        check("busy_in_drain", longint'(busy), 1);
        wait_done();
    endtask

    initial begin
        int bc;
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        x = '0; y = '0; z_approx = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // Single exact sample at operand maximum.
        stim_q.delete(); add(255, 255, 65025);
        run_samples(1, 0, 1'b0);

        // Two samples with errors of -1 and +100.
        stim_q.delete(); add(3, 5, 14); add(200, 100, 20100);
        run_samples(2, 0, 1'b0);

        // Extreme error distances.
        stim_q.delete(); add(0, 0, 65535); add(255, 255, 0);
        run_samples(2, 0, 1'b0);

        // Three samples of error 4 with valid pattern 1-0-0-1-0-1.
        stim_q.delete(); add(10, 10, 104); add(7, 8, 52); add(0, 0, 4);
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_samples(3, 0, 1'b0);
        pat_q.delete();

        // Zero-sample run: busy exactly three cycles, never ready.
        stim_q.delete();
        exp_q.push_back(model(0));
        @(posedge clk); #1;
        start = 1'b1; num_samples = '0;
        @(posedge clk); #1;
        start = 1'b0;
        bc = 0;
        while (busy && bc < 10) begin
            check("n0_in_ready", longint'(in_ready), 0);
            bc++;
            @(posedge clk); #1;
        end
        check("n0_busy_cycles", longint'(bc), 3);
        check("n0_done", longint'(done), 1);
        wait_done();

        // Reset after 5 of 10 samples discards the run.
        gen_random(10);
        @(posedge clk); #1;
        start = 1'b1; num_samples = CNT_W'(10);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x = stim_q[i].x; y = stim_q[i].y; z_approx = stim_q[i].z;
            @(posedge clk); #1;
        end
        check("pre_reset_cnt", longint'(sample_cnt), 5);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("midrun_reset");
        repeat (3) @(posedge clk);
        #1;
        check_zero("post_reset_flush");
        stim_q.delete(); add(17, 9, 160);
        run_samples(1, 0, 1'b0);

        // Start pulse while running is ignored.
        gen_random(6);
        run_samples(6, 0, 1'b1);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            int n = int'($urandom_range(1, 40));
            gen_random(n);
            run_samples(n, int'($urandom_range(60)), ($urandom_range(3) == 0));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amul_err_monitor.md
AMUL_ERR_MONITOR -- requirements
Module: amul_err_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of the sample counter and sample-count input.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that starts a measurement run; honoured only in IDLE or DONE.
REQ-005 num_samples  input  CNT_W  number of operand/product samples in the run; sampled on an accepted start.
REQ-006 in_valid  input  1  x, y and z_approx are valid this cycle.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 x  input  8  unsigned multiplicand presented to the approximate 8x8 multiplier.
REQ-009 y  input  8  unsigned multiplier presented to the approximate 8x8 multiplier.
REQ-010 z_approx  input  16  product returned by the approximate multiplier for the same x and y.
REQ-011 busy  output  1  high in RUN and DRAIN.
REQ-012 done  output  1  high in DONE; results are stable.
REQ-013 sample_cnt  output  CNT_W  number of samples accepted in the current or last run.
REQ-014 sum_ed  output  16+CNT_W  sum of |z_approx - x*y| over all accepted samples.
REQ-015 max_ed  output  16  largest single error distance in the run.
REQ-016 err_cnt  output  CNT_W  number of samples with a nonzero error distance.
REQ-017 sum_sed  output  17+CNT_W  two's-complement sum of (z_approx - x*y); see Configuration.

Function
REQ-018 States: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE or DONE with start=1: clear sample_cnt, sum_ed, max_ed, err_cnt and sum_sed, latch num_samples, go to RUN.
REQ-020 RUN: in_ready=1; a sample is accepted when in_valid && in_ready; accepted samples increment sample_cnt.
REQ-021 RUN: when the accepted count equals the latched num_samples, go to DRAIN next cycle; in_ready=0 from that cycle.
REQ-022 Latched num_samples=0: RUN lasts one cycle with in_ready=0 and no samples accepted, then DRAIN.
REQ-023 in_ready=0 in IDLE, DRAIN and DONE; in_valid is ignored in those states.
REQ-024 Pipeline stage 1 registers exact x*y (16 b) and z_approx. Stage 2 computes ed=|z_approx-exact| and sed=z_approx-exact (17 b signed) and updates the accumulators.
REQ-025 Accumulator update latency: 2 cycles after acceptance; bubbles (in_valid=0) do not update the accumulators.
REQ-026 max_ed is updated when ed > max_ed; err_cnt increments when ed != 0.
REQ-027 sum_ed cannot overflow: 16+CNT_W bits covers (2^CNT_W-1)*(2^16-1); no saturation logic is used.
REQ-028 DRAIN lasts exactly 2 cycles to flush the pipeline, then DONE.
REQ-029 DONE: done=1; outputs hold until the next accepted start.
REQ-030 start in RUN or DRAIN is ignored.
REQ-031 A start in the same cycle as the transition into DONE is ignored; start is honoured from the first DONE cycle.

Reset
REQ-032 rst=1 on a clock edge: state goes to IDLE; all outputs and accumulators go to 0 (in_ready=0, busy=0, done=0); pipeline valid bits are cleared.
REQ-033 Reset mid-run discards in-flight samples; no partial results remain visible.

Configuration
REQ-034 Macro AMUL_ERR_SIGNED_EN defined: sum_sed accumulates the signed error (bias) as in REQ-024.
REQ-035 Macro AMUL_ERR_SIGNED_EN undefined: the signed accumulator is not built and sum_sed is tied to 0; the port remains present.

Verification
REQ-036 N=1, x=255, y=255, z_approx=65025 -> done; sum_ed=0, max_ed=0, err_cnt=0, sample_cnt=1.
REQ-037 N=2, samples (3,5,14) and (200,100,20100) -> sum_ed=101, max_ed=100, err_cnt=2; sum_sed=99 with macro, 0 without.
REQ-038 N=3 with in_valid gaps (1-0-0-1-0-1), each sample carrying error 4 -> sum_ed=12, sample_cnt=3; in_ready drops on the cycle after the 3rd acceptance.
REQ-039 start with num_samples=0 -> busy for 3 cycles (RUN 1, DRAIN 2), then done=1 with all results 0.
REQ-040 rst asserted during RUN after 5 of 10 samples -> next cycle IDLE with all outputs 0; a new start with N=1 yields correct results.
REQ-041 start pulsed during RUN -> ignored; the run completes with the originally latched num_samples.
